// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch core: state encoding and digit limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } sw_state_t;

  // Even-index digits are units (0..9), odd-index digits are tens (0..5).
  localparam logic [3:0] DIGIT_LIM_LO = 4'd9;
  localparam logic [3:0] DIGIT_LIM_HI = 4'd5;

  // Highest value digit i may hold before wrapping to 0.
  function automatic logic [3:0] digit_limit(input int i);
    if ((i % 2) == 1) begin
      return DIGIT_LIM_HI;
    end else begin
      return DIGIT_LIM_LO;
    end
  endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// One BCD digit register. Increments on inc, wraps to 0 at limit and reports
// carry_out when a wrap happens; whether the carry is used is the caller's call.
module bcd_digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic [3:0] limit,
  output logic [3:0] value,
  output logic       carry_out
);

  logic [3:0] value_r;
  logic       at_lim_s;

  assign at_lim_s  = (value_r == limit);
  assign carry_out = inc & at_lim_s;
  assign value     = value_r;

  // Digit register: clear beats increment; increment wraps at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= 4'd0;
    end else if (clr) begin
      value_r <= 4'd0;
    end else if (inc) begin
      value_r <= at_lim_s ? 4'd0 : (value_r + 4'd1);
    end else begin
      value_r <= value_r;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// BCD stopwatch core: NUM_DIGITS digits counted in 00..59 pairs, with
// run/pause, clear, per-digit adjust and a blinking selected-digit mask.
// Optional lap hold is compiled in when STOPWATCH_LAP_EN is defined.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SEL_W      = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    adj_tick,
  input  logic                    blink_tick,
  input  logic                    btn_reset,
  input  logic                    btn_pause,
`ifdef STOPWATCH_LAP_EN
  input  logic                    btn_lap,
`endif
  input  logic                    adj,
  input  logic [SEL_W-1:0]        adj_sel,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    adjusting,
  output logic                    overflow,
  output logic [NUM_DIGITS-1:0]   blink_mask
);

  sw_state_t                 state_r;
  sw_state_t                 state_next_s;
  logic                      count_en_s;
  logic                      adj_en_s;
  logic [NUM_DIGITS-1:0]     sel_hit_s;
  logic [NUM_DIGITS-1:0]     inc_s;
  logic [NUM_DIGITS-1:0]     carry_s;
  logic [4*NUM_DIGITS-1:0]   live_s;
  logic                      phase_r;
  logic                      phase_next_s;
  logic                      overflow_r;
  logic [NUM_DIGITS-1:0]     mask_r;

  // Next state: adj dominates, leaving ADJUST lands in PAUSED, and the pause
  // toggle is suppressed by a simultaneous clear.
  always_comb begin
    state_next_s = state_r;
    if (adj) begin
      state_next_s = ADJUST;
    end else if (state_r == ADJUST) begin
      state_next_s = PAUSED;
    end else if (btn_pause && !btn_reset) begin
      case (state_r)
        PAUSED:  state_next_s = RUN;
        RUN:     state_next_s = PAUSED;
        default: state_next_s = PAUSED;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= PAUSED;
    end else begin
      state_r <= state_next_s;
    end
  end

  assign count_en_s = (state_r == RUN) && !adj && tick;
  assign adj_en_s   = (state_r == ADJUST) && adj && adj_tick;

  // One-hot decode of adj_sel; out-of-range selections decode to all zeros.
  always_comb begin
    sel_hit_s = {NUM_DIGITS{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_hit_s[i] = (adj_sel == SEL_W'(i));
    end
  end

  // Per-digit increment: in RUN a ripple carry through every digit sitting at
  // its limit; in ADJUST only the selected digit, with no carry onwards.
  always_comb begin
    logic chain;
    chain = count_en_s;
    inc_s = {NUM_DIGITS{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      inc_s[i] = chain | (adj_en_s & sel_hit_s[i]);
      chain    = chain & (live_s[4*i +: 4] == digit_limit(i));
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (btn_reset),
      .inc       (inc_s[g]),
      .limit     (digit_limit(g)),
      .value     (live_s[4*g +: 4]),
      .carry_out (carry_s[g])
    );
  end

  // Full-scale wrap pulse: every digit carried out while counting, unless cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= count_en_s && !btn_reset && (&carry_s);
    end
  end

  // Blink phase only advances while staying in ADJUST; anything else resets it.
  always_comb begin
    phase_next_s = 1'b0;
    if ((state_r == ADJUST) && (state_next_s == ADJUST)) begin
      phase_next_s = blink_tick ? !phase_r : phase_r;
    end else begin
      phase_next_s = 1'b0;
    end
  end

  // Blink phase and registered mask of the selected digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 1'b0;
      mask_r  <= {NUM_DIGITS{1'b0}};
    end else begin
      phase_r <= phase_next_s;
      mask_r  <= ((state_next_s == ADJUST) && phase_next_s) ? sel_hit_s
                                                             : {NUM_DIGITS{1'b0}};
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic                    hold_r;
  logic [4*NUM_DIGITS-1:0] lap_r;

  // Lap hold toggles only while staying in RUN; clear or leaving RUN drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= 1'b0;
      lap_r  <= {(4*NUM_DIGITS){1'b0}};
    end else if (btn_reset || (state_next_s != RUN)) begin
      hold_r <= 1'b0;
      lap_r  <= lap_r;
    end else if ((state_r == RUN) && btn_lap) begin
      hold_r <= !hold_r;
      lap_r  <= hold_r ? lap_r : live_s;
    end else begin
      hold_r <= hold_r;
      lap_r  <= lap_r;
    end
  end

  assign digits = hold_r ? lap_r : live_s;
`else
  assign digits = live_s;
`endif

  assign running    = (state_r == RUN);
  assign adjusting  = (state_r == ADJUST);
  assign overflow   = overflow_r;
  assign blink_mask = mask_r;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core. The reference model keeps the
// count as a plain number of seconds in base-60 pairs and converts to BCD.
module tb_stopwatch_core;

`ifdef STOPWATCH_LAP_EN
  localparam int ND = 6;
`else
  localparam int ND = 4;
`endif
  localparam int SW = 3;
  localparam int DW = 4 * ND;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0, adj_tick = 1'b0, blink_tick = 1'b0;
  logic          btn_reset = 1'b0, btn_pause = 1'b0, btn_lap = 1'b0;
  logic          adj = 1'b0;
  logic [SW-1:0] adj_sel = '0;
  logic [DW-1:0] digits;
  logic          running, adjusting, overflow;
  logic [ND-1:0] blink_mask;

  int checks = 0;
  int failures = 0;

  // model state: 0 paused, 1 run, 2 adjust
  int m_cnt, m_state, m_phase, m_hold, m_lap, m_ovf, m_mask;

  stopwatch_core #(.NUM_DIGITS(ND), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .adj_tick(adj_tick),
    .blink_tick(blink_tick), .btn_reset(btn_reset), .btn_pause(btn_pause),
`ifdef STOPWATCH_LAP_EN
    .btn_lap(btn_lap),
`endif
    .adj(adj), .adj_sel(adj_sel), .digits(digits), .running(running),
    .adjusting(adjusting), .overflow(overflow), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  function automatic int full_scale();
    int r = 1;
    for (int p = 0; p < ND / 2; p++) r = r * 60;
    return r;
  endfunction

  function automatic logic [DW-1:0] to_bcd(input int v);
    logic [DW-1:0] r = '0;
    int pair;
    for (int p = 0; p < ND / 2; p++) begin
      pair = v % 60;
      v = v / 60;
      r[8*p +: 4]     = 4'(pair % 10);
      r[8*p + 4 +: 4] = 4'(pair / 10);
    end
    return r;
  endfunction

  function automatic int adjust_digit(input int v, input int sel);
    int d[ND];
    int r, mult, lim;
    for (int p = 0; p < ND / 2; p++) begin
      d[2*p]     = (v % 60) % 10;
      d[2*p + 1] = (v % 60) / 10;
      v = v / 60;
    end
    lim = (sel % 2 == 1) ? 5 : 9;
    d[sel] = (d[sel] == lim) ? 0 : d[sel] + 1;
    r = 0;
    mult = 1;
    for (int p = 0; p < ND / 2; p++) begin
      r = r + (d[2*p + 1] * 10 + d[2*p]) * mult;
      mult = mult * 60;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_state = 0; m_phase = 0; m_hold = 0; m_lap = 0; m_ovf = 0; m_mask = 0;
  endtask

  task automatic model_update();
    int ns;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (adj) ns = 2;
    else if (m_state == 2) ns = 0;
    else if (btn_pause && !btn_reset) ns = (m_state == 0) ? 1 : 0;
    else ns = m_state;
`ifdef STOPWATCH_LAP_EN
    if (btn_reset || ns != 1) m_hold = 0;
    else if (m_state == 1 && btn_lap) begin
      if (m_hold == 0) m_lap = m_cnt;
      m_hold = (m_hold == 0) ? 1 : 0;
    end
`endif
    m_ovf = 0;
    if (btn_reset) m_cnt = 0;
    else if (m_state == 1 && !adj && tick) begin
      if (m_cnt == full_scale() - 1) begin
        m_cnt = 0;
        m_ovf = 1;
      end else m_cnt = m_cnt + 1;
    end else if (m_state == 2 && adj && adj_tick && int'(adj_sel) < ND)
      m_cnt = adjust_digit(m_cnt, int'(adj_sel));
    if (m_state == 2 && ns == 2) begin
      if (blink_tick) m_phase = 1 - m_phase;
    end else m_phase = 0;
    m_mask = (ns == 2 && m_phase == 1 && int'(adj_sel) < ND) ? (1 << adj_sel) : 0;
    m_state = ns;
  endtask

  task automatic compare_all();
    check("digits", 32'(digits), 32'(to_bcd(m_hold ? m_lap : m_cnt)));
    check("running", 32'(running), 32'(m_state == 1));
    check("adjusting", 32'(adjusting), 32'(m_state == 2));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("blink_mask", 32'(blink_mask), 32'(m_mask));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  // one cycle with the given pulses, then pulses drop
  task automatic cyc(input bit t, input bit at, input bit bt, input bit br, input bit bp);
    tick = t; adj_tick = at; blink_tick = bt; btn_reset = br; btn_pause = bp;
    step();
    tick = 1'b0; adj_tick = 1'b0; blink_tick = 1'b0; btn_reset = 1'b0;
    btn_pause = 1'b0; btn_lap = 1'b0;
  endtask

  task automatic adj_digit(input int sel, input int n);
    adj_sel = SW'(sel);
    repeat (n) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (2) step();
    check("reset_digits", 32'(digits), 32'd0);
    check("reset_running", 32'(running), 32'd0);
    check("reset_mask", 32'(blink_mask), 32'd0);
    rst_n = 1'b1;

    // run 75 seconds
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (75) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("count75", 32'(digits[15:0]), 32'h0115);
    check("count75_running", 32'(running), 32'd1);

    // preload full scale, then wrap
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    adj = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < ND; i++) adj_digit(i, (i % 2 == 1) ? 5 : 9);
    adj = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("preload", 32'(digits[15:0]), 32'h5959);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_digits", 32'(digits), 32'd0);
    check("wrap_overflow", 32'(overflow), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("overflow_one_cycle", 32'(overflow), 32'd0);

    // tick and pause together
    repeat (7) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("tick_pause", 32'(digits[15:0]), 32'h0008);
    check("tick_pause_state", 32'(running), 32'd0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("paused_hold", 32'(digits[15:0]), 32'h0008);

    // adjust digit 1 with blink
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    adj = 1'b1;
    adj_sel = SW'(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    adj_digit(1, 7);
    check("adj_wrap", 32'(digits[15:0]), 32'h0010);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("blink_on", 32'(blink_mask), 32'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("blink_off", 32'(blink_mask), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    adj = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("leave_adj_mask", 32'(blink_mask), 32'd0);
    check("leave_adj_state", 32'(adjusting), 32'd0);

    // 12:34 then clear with tick in RUN
    adj = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    adj_digit(0, 4); adj_digit(1, 2); adj_digit(2, 2); adj_digit(3, 1);
    adj = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("preload_1234", 32'(digits[15:0]), 32'h1234);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("clear_tick", 32'(digits), 32'd0);
    check("clear_keeps_run", 32'(running), 32'd1);

    // asynchronous reset mid-count
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_digits", 32'(digits), 32'd0);
    check("async_running", 32'(running), 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    model_reset();
    step();
    rst_n = 1'b1;

`ifdef STOPWATCH_LAP_EN
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (10) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    btn_lap = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lap_hold", 32'(digits), 32'h10);
    btn_lap = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lap_release", 32'(digits), 32'h15);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) adj = ~adj;
      if ($urandom_range(0, 7) == 0) adj_sel = SW'($urandom_range(0, 7));
      btn_lap = ($urandom_range(0, 9) == 0);
      cyc($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
